// File: rtl/riscv_lsu.sv
// Multi-cycle RISC-V load/store unit between the execute stage and a byte-lane data memory.
// Handles width decode, lane steering, sign/zero extension and fault reporting.
module riscv_lsu #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned LANES       = XLEN / 8,
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_is_store,
   input  logic [2:0]       req_funct3,
   input  logic [XLEN-1:0]  req_addr,
   input  logic [XLEN-1:0]  req_wdata,
   input  logic [4:0]       req_rd,
   output logic             resp_valid,
   output logic [XLEN-1:0]  resp_rdata,
   output logic [4:0]       resp_rd,
   output logic             resp_fault,
   output logic [XLEN-1:0]  mem_addr,
   output logic [7:0]       mem_data_in  [LANES],
   input  logic [7:0]       mem_data_out [LANES],
   output logic             mem_write_en,
   output logic [LANES-1:0] mem_byte_en
);
   localparam int unsigned OFFW = $clog2(LANES);
   localparam int unsigned XW   = $clog2(XLEN);
   localparam int unsigned CNTW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, STORE, LOAD, RESP} state_t;

   state_t          state;
   logic [CNTW-1:0] cnt;
   logic [OFFW-1:0] off_q;
   logic [2:0]      funct3_q;
   logic [4:0]      rd_q;

   logic [OFFW-1:0]  off_c;
   logic [XLEN-1:0]  word_addr_c;
   logic [3:0]       size_mask_c;
   logic             legal_c;
   logic             fault_c;
   logic [7:0]       st_lane_c [LANES];
   logic [LANES-1:0] st_be_c;
   logic [XLEN-1:0]  ld_word_c;
   logic [XLEN-1:0]  ld_shift_c;
   logic [XLEN-1:0]  ld_mask_c;
   logic [XLEN-1:0]  ld_data_c;
   int               nbits_c;

   assign off_c       = req_addr[OFFW-1:0];
   assign word_addr_c = {req_addr[XLEN-1:OFFW], OFFW'(0)};
   assign size_mask_c = 4'((4'd1 << req_funct3[1:0]) - 4'd1);

   // Request width legality and alignment
   always_comb begin
      legal_c = 1'b0;
      if (req_is_store) begin
         legal_c = (req_funct3 <= 3'd2) || ((XLEN == 64) && (req_funct3 == 3'd3));
      end else begin
         case (req_funct3)
            3'd0, 3'd1, 3'd2, 3'd4, 3'd5: legal_c = 1'b1;
            3'd3, 3'd6:                   legal_c = (XLEN == 64);
            default:                      legal_c = 1'b0;
         endcase
      end
      fault_c = !legal_c || ((4'(off_c) & size_mask_c) != 4'd0);
   end

   // Steer the low store bytes onto lanes off..off+size-1
   always_comb begin
      for (int i = 0; i < int'(LANES); i++) begin
         st_lane_c[i] = 8'h00;
         st_be_c[i]   = 1'b0;
         if ((i >= int'(off_c)) && (i < int'(off_c) + (1 << req_funct3[1:0]))) begin
            st_lane_c[i] = 8'(req_wdata >> (8 * (i - int'(off_c))));
            st_be_c[i]   = 1'b1;
         end
      end
   end

   // Align the returned word to the access offset and extend to XLEN
   always_comb begin
      for (int i = 0; i < int'(LANES); i++) begin
         ld_word_c[8*i +: 8] = mem_data_out[i];
      end
      ld_shift_c = ld_word_c >> {off_q, 3'b000};
      nbits_c    = 8 << funct3_q[1:0];
      ld_mask_c  = '1;
      ld_data_c  = ld_shift_c;
      if (nbits_c < int'(XLEN)) begin
         ld_mask_c = (XLEN'(1) << nbits_c) - XLEN'(1);
         ld_data_c = ld_shift_c & ld_mask_c;
         if (!funct3_q[2] && ld_shift_c[XW'(nbits_c - 1)]) begin
            ld_data_c = ld_data_c | ~ld_mask_c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state        <= IDLE;
         req_ready    <= 1'b1;
         cnt          <= '0;
         off_q        <= '0;
         funct3_q     <= '0;
         rd_q         <= '0;
         resp_valid   <= 1'b0;
         resp_rdata   <= '0;
         resp_rd      <= '0;
         resp_fault   <= 1'b0;
         mem_addr     <= '0;
         mem_data_in  <= '{default: 8'h00};
         mem_write_en <= 1'b0;
         mem_byte_en  <= '0;
      end else begin
         resp_valid   <= 1'b0;
         mem_write_en <= 1'b0;
         mem_byte_en  <= '0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  off_q     <= off_c;
                  funct3_q  <= req_funct3;
                  rd_q      <= req_rd;
                  if (fault_c) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= '0;
                     resp_rd    <= req_rd;
                     resp_fault <= 1'b1;
                  end else if (req_is_store) begin
                     state        <= STORE;
                     mem_addr     <= word_addr_c;
                     mem_data_in  <= st_lane_c;
                     mem_byte_en  <= st_be_c;
                     mem_write_en <= 1'b1;
                     resp_valid   <= 1'b1;
                     resp_rdata   <= '0;
                     resp_rd      <= '0;
                     resp_fault   <= 1'b0;
                  end else begin
                     state    <= LOAD;
                     mem_addr <= word_addr_c;
                     cnt      <= CNTW'(MEM_LATENCY - 1);
                  end
               end
            end
            STORE: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            LOAD: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNTW'(1);
               end else begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= ld_data_c;
                  resp_rd    <= rd_q;
                  resp_fault <= 1'b0;
               end
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: a latency-1 instance with a small byte memory,
// and a latency-3 instance for ready windowing and reset abort.
module tb_riscv_lsu;

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic [4:0]  rd;
      logic        fault;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] lanes;
      int          lat;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_b;
   logic rst3_b;
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t q1[$];
   exp_t q3[$];
   logic [7:0] mem [64];

   logic        req_valid, req_ready, req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        resp_valid, resp_fault;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_rd;
   logic [31:0] mem_addr;
   logic [7:0]  mem_data_in  [4];
   logic [7:0]  mem_data_out [4];
   logic        mem_write_en;
   logic [3:0]  mem_byte_en;

   logic        req_valid3, req_ready3, req_is_store3;
   logic [2:0]  req_funct3_3;
   logic [31:0] req_addr3, req_wdata3;
   logic [4:0]  req_rd3;
   logic        resp_valid3, resp_fault3;
   logic [31:0] resp_rdata3;
   logic [4:0]  resp_rd3;
   logic [31:0] mem_addr3;
   logic [7:0]  mem_data_in3  [4];
   logic [7:0]  mem_data_out3 [4];
   logic        mem_write_en3;
   logic [3:0]  mem_byte_en3;

   riscv_lsu #(.XLEN(32), .LANES(4), .MEM_LATENCY(1)) dut1 (
      .clk(clk), .rst_b(rst_b),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_fault(resp_fault),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .mem_write_en(mem_write_en), .mem_byte_en(mem_byte_en)
   );

   riscv_lsu #(.XLEN(32), .LANES(4), .MEM_LATENCY(3)) dut3 (
      .clk(clk), .rst_b(rst3_b),
      .req_valid(req_valid3), .req_ready(req_ready3), .req_is_store(req_is_store3),
      .req_funct3(req_funct3_3), .req_addr(req_addr3), .req_wdata(req_wdata3), .req_rd(req_rd3),
      .resp_valid(resp_valid3), .resp_rdata(resp_rdata3), .resp_rd(resp_rd3), .resp_fault(resp_fault3),
      .mem_addr(mem_addr3), .mem_data_in(mem_data_in3), .mem_data_out(mem_data_out3),
      .mem_write_en(mem_write_en3), .mem_byte_en(mem_byte_en3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Byte memory behind dut1: combinational read, byte-enabled write
   always @(posedge clk) begin
      if (!rst_b) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
         mem[0] <= 8'h11; mem[1] <= 8'h22; mem[2] <= 8'h33; mem[3] <= 8'h80;
         mem[4] <= 8'h7F; mem[5] <= 8'hFF; mem[6] <= 8'h01; mem[7] <= 8'h80;
      end else if (mem_write_en) begin
         for (int i = 0; i < 4; i++)
            if (mem_byte_en[i]) mem[{mem_addr[5:2], 2'(i)}] <= mem_data_in[i];
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) mem_data_out[i] = mem[{mem_addr[5:2], 2'(i)}];
   end

   assign mem_data_out3 = '{8'h11, 8'h22, 8'h33, 8'h80};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : mon1
      exp_t e;
      if (mem_write_en && !resp_valid) begin
         n_tests++; n_fail++;
         $display("[TB] FAIL stray_write: mem_write_en=1 without a store response");
      end
      if (resp_valid) begin
         if (q1.size() == 0) begin
            n_tests++; n_fail++;
            $display("[TB] FAIL unexpected_resp: rdata=0x%0h with nothing pending", resp_rdata);
         end else begin
            e = q1.pop_front();
            chk({e.tag, " rdata"}, resp_rdata, e.rdata);
            chk({e.tag, " rd"}, 32'(resp_rd), 32'(e.rd));
            chk({e.tag, " fault"}, 32'(resp_fault), 32'(e.fault));
            chk({e.tag, " write_en"}, 32'(mem_write_en), 32'(e.we));
            chk({e.tag, " latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
            if (e.we) begin
               chk({e.tag, " mem_addr"}, mem_addr, e.addr);
               chk({e.tag, " byte_en"}, 32'(mem_byte_en), 32'(e.be));
               chk({e.tag, " lanes"}, {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]}, e.lanes);
            end
         end
      end
   end

   always @(negedge clk) begin : mon3
      exp_t e;
      if (mem_write_en3) begin
         n_tests++; n_fail++;
         $display("[TB] FAIL stray_write3: mem_write_en asserted on load-only instance");
      end
      if (resp_valid3) begin
         if (q3.size() == 0) begin
            n_tests++; n_fail++;
            $display("[TB] FAIL unexpected_resp3: rdata=0x%0h with nothing pending", resp_rdata3);
         end else begin
            e = q3.pop_front();
            chk({e.tag, " rdata"}, resp_rdata3, e.rdata);
            chk({e.tag, " rd"}, 32'(resp_rd3), 32'(e.rd));
            chk({e.tag, " fault"}, 32'(resp_fault3), 32'(e.fault));
            chk({e.tag, " latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
         end
      end
   end

   task automatic issue1(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] e_rdata, input logic e_fault,
                         input logic [3:0] e_be, input logic [31:0] e_lanes);
      exp_t e;
      int   budget = 0;
      @(negedge clk);
      while (!req_ready && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (!req_ready) begin
         n_tests++; n_fail++;
         $display("[TB] FAIL %s ready_timeout: req_ready=0 after %0d cycles", tag, budget);
         return;
      end
      req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
      req_addr = addr; req_wdata = wdata; req_rd = rd;
      e.tag   = tag;
      e.rdata = e_rdata;
      e.rd    = (st && !e_fault) ? 5'd0 : rd;
      e.fault = e_fault;
      e.we    = st && !e_fault;
      e.addr  = {addr[31:2], 2'b00};
      e.be    = e_be;
      e.lanes = e_lanes;
      e.lat   = (st || e_fault) ? 1 : 2;
      e.acc   = cyc + 1;
      q1.push_back(e);
      @(negedge clk);
      req_valid = 1'b0; req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
   endtask

   initial begin
      exp_t e;
      int   low;
      int   budget;
      rst_b = 1'b0; rst3_b = 1'b0;
      req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
      req_addr = '0; req_wdata = '0; req_rd = '0;
      req_valid3 = 1'b0; req_is_store3 = 1'b0; req_funct3_3 = 3'd0;
      req_addr3 = '0; req_wdata3 = '0; req_rd3 = '0;
      repeat (3) @(negedge clk);
      chk("reset req_ready", 32'(req_ready), 32'd1);
      chk("reset resp_valid", 32'(resp_valid), 32'd0);
      chk("reset resp_rdata", resp_rdata, 32'd0);
      chk("reset mem_addr", mem_addr, 32'd0);
      chk("reset write_en", 32'(mem_write_en), 32'd0);
      chk("reset byte_en", 32'(mem_byte_en), 32'd0);
      rst_b = 1'b1; rst3_b = 1'b1;

      //      tag          st    f3    addr          wdata         rd     rdata          flt   be       lanes
      issue1("lw_100",    1'b0, 3'd2, 32'h100, 32'h0,        5'd5,  32'h80332211, 1'b0, 4'h0, 32'h0);
      issue1("lb_103",    1'b0, 3'd0, 32'h103, 32'h0,        5'd6,  32'hFFFFFF80, 1'b0, 4'h0, 32'h0);
      issue1("lbu_103",   1'b0, 3'd4, 32'h103, 32'h0,        5'd7,  32'h00000080, 1'b0, 4'h0, 32'h0);
      issue1("lh_102",    1'b0, 3'd1, 32'h102, 32'h0,        5'd8,  32'hFFFF8033, 1'b0, 4'h0, 32'h0);
      issue1("lhu_102",   1'b0, 3'd5, 32'h102, 32'h0,        5'd9,  32'h00008033, 1'b0, 4'h0, 32'h0);
      issue1("lb_104",    1'b0, 3'd0, 32'h104, 32'h0,        5'd10, 32'h0000007F, 1'b0, 4'h0, 32'h0);
      issue1("lh_104",    1'b0, 3'd1, 32'h104, 32'h0,        5'd11, 32'hFFFFFF7F, 1'b0, 4'h0, 32'h0);
      issue1("lhu_106",   1'b0, 3'd5, 32'h106, 32'h0,        5'd12, 32'h00008001, 1'b0, 4'h0, 32'h0);
      issue1("lb_105",    1'b0, 3'd0, 32'h105, 32'h0,        5'd13, 32'hFFFFFFFF, 1'b0, 4'h0, 32'h0);
      issue1("sh_102",    1'b1, 3'd1, 32'h102, 32'hDEADBEEF, 5'd14, 32'h0,        1'b0, 4'hC, 32'hBEEF0000);
      issue1("lw_after_sh", 1'b0, 3'd2, 32'h100, 32'h0,      5'd15, 32'hBEEF2211, 1'b0, 4'h0, 32'h0);
      issue1("sb_101",    1'b1, 3'd0, 32'h101, 32'h123456A5, 5'd16, 32'h0,        1'b0, 4'h2, 32'h0000A500);
      issue1("lw_after_sb", 1'b0, 3'd2, 32'h100, 32'h0,      5'd17, 32'hBEEFA511, 1'b0, 4'h0, 32'h0);
      issue1("sw_104",    1'b1, 3'd2, 32'h104, 32'h12345678, 5'd18, 32'h0,        1'b0, 4'hF, 32'h12345678);
      issue1("lw_104",    1'b0, 3'd2, 32'h104, 32'h0,        5'd19, 32'h12345678, 1'b0, 4'h0, 32'h0);
      issue1("lw_102_mis", 1'b0, 3'd2, 32'h102, 32'h0,       5'd20, 32'h0,        1'b1, 4'h0, 32'h0);
      issue1("sw_101_mis", 1'b1, 3'd2, 32'h101, 32'hCAFEF00D, 5'd21, 32'h0,       1'b1, 4'h0, 32'h0);
      issue1("lh_101_mis", 1'b0, 3'd1, 32'h101, 32'h0,       5'd22, 32'h0,        1'b1, 4'h0, 32'h0);
      issue1("sh_103_mis", 1'b1, 3'd1, 32'h103, 32'hFFFF,    5'd23, 32'h0,        1'b1, 4'h0, 32'h0);
      issue1("ld_f3_3",   1'b0, 3'd3, 32'h100, 32'h0,        5'd24, 32'h0,        1'b1, 4'h0, 32'h0);
      issue1("lwu_f3_6",  1'b0, 3'd6, 32'h100, 32'h0,        5'd25, 32'h0,        1'b1, 4'h0, 32'h0);
      issue1("ld_f3_7",   1'b0, 3'd7, 32'h100, 32'h0,        5'd26, 32'h0,        1'b1, 4'h0, 32'h0);
      issue1("st_f3_4",   1'b1, 3'd4, 32'h100, 32'h55,       5'd27, 32'h0,        1'b1, 4'h0, 32'h0);
      issue1("lbu_100",   1'b0, 3'd4, 32'h100, 32'h0,        5'd28, 32'h00000011, 1'b0, 4'h0, 32'h0);
      issue1("lw_nowrite", 1'b0, 3'd2, 32'h100, 32'h0,       5'd29, 32'hBEEFA511, 1'b0, 4'h0, 32'h0);

      budget = 0;
      while (q1.size() != 0 && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      if (q1.size() != 0) begin
         n_tests++; n_fail++;
         $display("[TB] FAIL drain1: %0d responses still pending", q1.size());
      end

      // Latency-3 load with a second request held valid behind it
      @(negedge clk);
      req_valid3 = 1'b1; req_is_store3 = 1'b0; req_funct3_3 = 3'd2;
      req_addr3 = 32'h100; req_rd3 = 5'd1;
      e.tag = "lat3_lw"; e.rdata = 32'h80332211; e.rd = 5'd1; e.fault = 1'b0; e.we = 1'b0;
      e.addr = '0; e.be = '0; e.lanes = '0; e.lat = 4; e.acc = cyc + 1;
      q3.push_back(e);
      @(negedge clk);
      req_funct3_3 = 3'd4; req_addr3 = 32'h103; req_rd3 = 5'd2;
      low = 0;
      while (!req_ready3 && low < 20) begin
         low++;
         @(negedge clk);
      end
      chk("lat3 ready_low_cycles", 32'(low), 32'd4);
      e.tag = "lat3_lbu"; e.rdata = 32'h00000080; e.rd = 5'd2; e.acc = cyc + 1;
      q3.push_back(e);
      @(negedge clk);
      req_valid3 = 1'b0;

      budget = 0;
      while (q3.size() != 0 && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      if (q3.size() != 0) begin
         n_tests++; n_fail++;
         $display("[TB] FAIL drain3: %0d responses still pending", q3.size());
      end

      // Reset in the middle of the load wait: no response may follow
      @(negedge clk);
      req_valid3 = 1'b1; req_funct3_3 = 3'd2; req_addr3 = 32'h100; req_rd3 = 5'd3;
      @(negedge clk);
      req_valid3 = 1'b0;
      @(negedge clk);
      rst3_b = 1'b0;
      #1;
      chk("abort resp_valid", 32'(resp_valid3), 32'd0);
      chk("abort req_ready", 32'(req_ready3), 32'd1);
      chk("abort resp_rdata", resp_rdata3, 32'd0);
      chk("abort resp_rd", 32'(resp_rd3), 32'd0);
      chk("abort mem_addr", mem_addr3, 32'd0);
      repeat (2) @(negedge clk);
      rst3_b = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort ready_after_release", 32'(req_ready3), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Parametrised multi-cycle load/store unit that sits between the RISC-V core's execute stage and the byte-lane data memory. It replaces direct combinational mem_addr/mem_write_en driving. It supports XLEN 32/64, configurable memory read latency, per-lane byte enables, sign/zero extension, and misaligned/illegal-width fault reporting. It uses a valid/ready request side and a single-cycle response pulse.

Parameters:
XLEN, 32, data/address width; legal values 32 or 64.
LANES, XLEN/8, byte lanes per memory word.
MEM_LATENCY, 1, cycles from mem_addr presented to mem_data_out valid; minimum 1 (1 = combinational memory).

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst_b  in  1  asynchronous active-low reset.
req_valid  in  1  core presents a memory op.
req_ready  out  1  LSU can accept; high only in IDLE.
req_is_store  in  1  1=store, 0=load.
req_funct3  in  3  RISC-V width/sign field.
req_addr  in  XLEN  effective byte address.
req_wdata  in  XLEN  store data (rs2), low-aligned.
req_rd  in  5  load destination register.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  XLEN  extended load data; 0 for stores/faults.
resp_rd  out  5  echoed req_rd; 0 for stores.
resp_fault  out  1  misaligned or illegal width.
mem_addr  out  XLEN  word-aligned address (low log2(LANES) bits 0).
mem_data_in  out  LANES x 8 (unpacked)  write bytes to memory, lane 0 = lowest address.
mem_data_out  in  LANES x 8 (unpacked)  read bytes from memory.
mem_write_en  out  1  write strobe.
mem_byte_en  out  LANES  per-lane write enable.

Behaviour:
- Reset (async, rst_b=0): state=IDLE; resp_valid=0, resp_rdata=0, resp_rd=0, resp_fault=0, mem_addr=0, all mem_data_in lanes=0, mem_write_en=0, mem_byte_en=0; wait counter=0.
- Asserting reset mid-operation aborts the operation. No write occurs and no response is issued.
- req_ready is high iff state==IDLE. A request is accepted on a rising edge with req_valid && req_ready. Request fields are registered at acceptance and need not be held afterwards.
- Little-endian. off = req_addr[log2(LANES)-1:0].
- Width decode:
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. With XLEN=64 also 3 LD and 6 LWU.
  - Stores: 0 SB, 1 SH, 2 SW. With XLEN=64 also 3 SD.
  - Any other funct3 is illegal.
- Misaligned: the access size (1/2/4/8 bytes) does not divide off.
- States: IDLE, STORE, LOAD, RESP.
- Transitions from IDLE on accept:
  - fault → RESP.
  - store → STORE.
  - load → LOAD with counter=MEM_LATENCY-1.
- STORE, 1 cycle:
  - mem_write_en=1; mem_addr=word address.
  - Size-many low bytes of wdata are placed in lanes off..off+size-1, and mem_byte_en is set on those lanes. Other lanes are driven 0 with enable 0.
  - resp_valid=1 in this same cycle, with resp_fault=0, resp_rdata=0 and resp_rd=0.
  - Next state IDLE.
- LOAD:
  - mem_addr held; mem_write_en=0.
  - Each cycle, if counter≠0 decrement; else sample mem_data_out at that edge and go to RESP.
  - Result: bytes from lane off upward, size bytes. Sign-extended to XLEN for LB/LH/LW(XLEN=64)/LD; zero-extended for LBU/LHU/LWU. LW with XLEN=32 is unextended.
- RESP, 1 cycle:
  - resp_valid=1 with the registered rdata/rd/fault.
  - Fault case: rdata=0, rd=req_rd, fault=1, and no memory strobe at any point.
  - Next state IDLE.
- Latency:
  - Store: resp_valid 1 cycle after acceptance.
  - Load: MEM_LATENCY+1 cycles after acceptance.
  - Fault: 1 cycle after acceptance.
  - Back-to-back throughput is one op per (latency+1) cycles, because req_ready is high in the IDLE cycle only.
- Outside STORE, mem_write_en=0 and mem_byte_en=0. mem_addr keeps its last value.
- resp_* outputs other than resp_valid hold their value until the next response.

Test Plan:
- Memory word @0x100 = bytes {0x11,0x22,0x33,0x80}. LW 0x100, MEM_LATENCY=1 → resp_valid 2 cycles after accept, rdata=0x80332211, fault=0.
- LB 0x103 → rdata=0xFFFFFF80. LBU 0x103 → 0x00000080. LH 0x102 → 0xFFFF8033.
- SH 0x102, wdata=0xDEADBEEF → single cycle with mem_write_en=1, mem_addr=0x100, byte_en=4'b1100, lanes[2]=0xEF, lanes[3]=0xBE, resp_valid in the same cycle.
- LW 0x102 and SW 0x101 → resp_fault=1 one cycle after accept, mem_write_en never asserted, rdata=0. funct3=3 with XLEN=32 → fault.
- MEM_LATENCY=3, LW 0x100 → req_ready low for 4 cycles, resp_valid at cycle 4. A second req_valid held high is accepted only in the IDLE cycle after the response.
- Assert rst_b low during LOAD wait (cycle 2 of 3) → outputs return to reset values immediately. No resp_valid. req_ready=1 after release.
